// File: rtl/lbm_step_scheduler_if.sv
// rtl/lbm_step_scheduler_if.sv - engine start/done handshakes and BRAM bank-owner select
interface lbm_step_scheduler_if;
  logic       collide_start_out;
  logic       collide_done_in;
  logic       stream_start_out;
  logic       stream_done_in;
  logic [1:0] bram_owner_out;

  modport master (
    output collide_start_out,
    output stream_start_out,
    output bram_owner_out,
    input  collide_done_in,
    input  stream_done_in
  );

  modport slave (
    input  collide_start_out,
    input  stream_start_out,
    input  bram_owner_out,
    output collide_done_in,
    output stream_done_in
  );
endinterface

// File: rtl/lbm_step_scheduler.sv
// rtl/lbm_step_scheduler.sv - LBM timestep sequencer (collide then stream) with BRAM owner select
// Optional engine-wait watchdog enabled by defining LBM_WATCHDOG_EN.
module lbm_step_scheduler #(
  parameter int COUNT_W         = 16,
  parameter int STEPS_PER_FRAME = 1,
  parameter int SYNC_TO_FRAME   = 1,
  parameter int WD_CYCLES       = 1 << 20
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                run_in,
  input  logic                step_in,
  input  logic                vsync_in,
  lbm_step_scheduler_if.master eng,
  output logic                busy_out,
  output logic                step_done_out,
  output logic [COUNT_W-1:0]  step_count_out,
  output logic                error_out
);

  localparam int BATCH_W = (STEPS_PER_FRAME < 1) ? 1 : $clog2(STEPS_PER_FRAME + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_SYNC, C_START, C_WAIT, S_START, S_WAIT, STEP_END, FAULT
  } state_t;

  state_t               state_q, state_d;
  logic                 single_q, single_d;
  logic [BATCH_W-1:0]   batch_q, batch_d;
  logic                 wd_expired;

  logic                 collide_start_d, stream_start_d, busy_d, step_done_d, error_d;
  logic [1:0]           owner_d;

`ifdef LBM_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Cleared while in a start state so every wait begins counting from zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wd_q <= '0;
    end else if (state_q == C_START || state_q == S_START) begin
      wd_q <= '0;
    end else if (state_q == C_WAIT || state_q == S_WAIT) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_expired = (wd_q == WD_W'(WD_CYCLES - 1));
`else
  logic unused_wd;
  assign unused_wd  = (WD_CYCLES > 0);
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= IDLE;
      single_q       <= 1'b0;
      batch_q        <= '0;
      step_count_out <= '0;
    end else begin
      state_q  <= state_d;
      single_q <= single_d;
      batch_q  <= batch_d;
      if (state_d == STEP_END) begin
        step_count_out <= step_count_out + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    batch_d  = batch_q;
    case (state_q)
      IDLE: begin
        if (run_in) begin
          single_d = 1'b0;
          batch_d  = '0;
          state_d  = (SYNC_TO_FRAME != 0) ? WAIT_SYNC : C_START;
        end else if (step_in) begin
          single_d = 1'b1;
          batch_d  = '0;
          state_d  = C_START;
        end
      end
      WAIT_SYNC: begin
        if (!run_in) begin
          state_d = IDLE;
        end else if (vsync_in) begin
          batch_d = '0;
          state_d = C_START;
        end
      end
      C_START: state_d = C_WAIT;
      C_WAIT: begin
        if (eng.collide_done_in) state_d = S_START;
        else if (wd_expired)     state_d = FAULT;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (eng.stream_done_in) begin
          batch_d = batch_q + 1'b1;
          state_d = STEP_END;
        end else if (wd_expired) begin
          state_d = FAULT;
        end
      end
      STEP_END: begin
        if (single_q || !run_in) begin
          state_d = IDLE;
        end else if (batch_q == BATCH_W'(STEPS_PER_FRAME)) begin
          // Without frame pacing a finished batch simply rolls into the next one.
          if (SYNC_TO_FRAME != 0) begin
            state_d = WAIT_SYNC;
          end else begin
            batch_d = '0;
            state_d = C_START;
          end
        end else begin
          state_d = C_START;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    collide_start_d = (state_d == C_START);
    stream_start_d  = (state_d == S_START);
    busy_d          = (state_d != IDLE);
    step_done_d     = (state_d == STEP_END);
`ifdef LBM_WATCHDOG_EN
    error_d         = (state_d == FAULT);
`else
    error_d         = 1'b0;
`endif
    case (state_d)
      C_START, C_WAIT: owner_d = 2'd1;
      S_START, S_WAIT: owner_d = 2'd2;
      default:         owner_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      eng.collide_start_out <= 1'b0;
      eng.stream_start_out  <= 1'b0;
      eng.bram_owner_out    <= 2'd0;
      busy_out              <= 1'b0;
      step_done_out         <= 1'b0;
      error_out             <= 1'b0;
    end else begin
      eng.collide_start_out <= collide_start_d;
      eng.stream_start_out  <= stream_start_d;
      eng.bram_owner_out    <= owner_d;
      busy_out              <= busy_d;
      step_done_out         <= step_done_d;
      error_out             <= error_d;
    end
  end

endmodule

// File: tb/tb_lbm_step_scheduler.sv
// tb/tb_lbm_step_scheduler.sv - directed bench for lbm_step_scheduler (LBM_WATCHDOG_EN aware)
module tb_lbm_step_scheduler;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // DUT A: frame-paced, 3 steps per frame, 4-bit counter, short watchdog
  logic       run_a = 0, step_a = 0, vsync_a = 0;
  logic       auto_a = 0, man_ca = 0, man_sa = 0;
  logic       busy_a, done_a, err_a;
  logic [3:0] cnt_a;
  logic [9:0] sh_ca, sh_sa;
  lbm_step_scheduler_if ifa ();

  lbm_step_scheduler #(.COUNT_W(4), .STEPS_PER_FRAME(3), .SYNC_TO_FRAME(1), .WD_CYCLES(64)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .run_in(run_a), .step_in(step_a), .vsync_in(vsync_a),
    .eng(ifa.master), .busy_out(busy_a), .step_done_out(done_a), .step_count_out(cnt_a),
    .error_out(err_a));

  // DUT B: unpaced free-run, one step per batch
  logic        run_b = 0, step_b = 0, vsync_b = 0;
  logic        busy_b, done_b, err_b;
  logic [15:0] cnt_b;
  logic [2:0]  sh_cb, sh_sb;
  lbm_step_scheduler_if ifb ();

  lbm_step_scheduler #(.COUNT_W(16), .STEPS_PER_FRAME(1), .SYNC_TO_FRAME(0)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .run_in(run_b), .step_in(step_b), .vsync_in(vsync_b),
    .eng(ifb.master), .busy_out(busy_b), .step_done_out(done_b), .step_count_out(cnt_b),
    .error_out(err_b));

  // Engine models: done follows start by a fixed delay (10 cycles for A, 3 for B)
  always @(posedge clk_in) begin
    if (!rst_in) begin
      sh_ca <= '0; sh_sa <= '0; sh_cb <= '0; sh_sb <= '0;
    end else begin
      sh_ca <= {sh_ca[8:0], ifa.collide_start_out & auto_a};
      sh_sa <= {sh_sa[8:0], ifa.stream_start_out & auto_a};
      sh_cb <= {sh_cb[1:0], ifb.collide_start_out};
      sh_sb <= {sh_sb[1:0], ifb.stream_start_out};
    end
  end
  assign ifa.collide_done_in = (sh_ca[9] & auto_a) | man_ca;
  assign ifa.stream_done_in  = (sh_sa[9] & auto_a) | man_sa;
  assign ifb.collide_done_in = sh_cb[2];
  assign ifb.stream_done_in  = sh_sb[2];

  int n_cs_a = 0, n_ss_a = 0, n_sd_a = 0, n_cs_b = 0, n_sd_b = 0;
  always @(negedge clk_in) begin
    n_cs_a <= n_cs_a + int'(ifa.collide_start_out);
    n_ss_a <= n_ss_a + int'(ifa.stream_start_out);
    n_sd_a <= n_sd_a + int'(done_a);
    n_cs_b <= n_cs_b + int'(ifb.collide_start_out);
    n_sd_b <= n_sd_b + int'(done_b);
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_done_a(input string tag, input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!done_a && n < bound);
    check(tag, done_a, 1);
  endtask

  task automatic single_step_a();
    step_a = 1; tick(); step_a = 0;
  endtask

  int cs0, ss0, sd0;

  initial begin
    // Reset values
    tick(2);
    check("rst_owner", ifa.bram_owner_out, 0);
    check("rst_busy", busy_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_err", err_a, 0);
    rst_in = 1; tick();

    // Single step with auto engines: start latency, owner in each phase, completion
    auto_a = 1;
    single_step_a();
    check("ss_cstart", ifa.collide_start_out, 1);
    check("ss_cowner", ifa.bram_owner_out, 1);
    tick();
    check("ss_cstart_1cyc", ifa.collide_start_out, 0);
    check("ss_cwait_owner", ifa.bram_owner_out, 1);
    wait_done_a("ss_tmo", 100);
    check("ss_count", cnt_a, 1);
    check("ss_done_owner", ifa.bram_owner_out, 0);
    tick();
    check("ss_idle", busy_a, 0);
    check("ss_cpulses", n_cs_a, 1);
    check("ss_spulses", n_ss_a, 1);

    // Stream done during C_WAIT is ignored
    auto_a = 0;
    single_step_a();
    tick();
    man_sa = 1; tick(); man_sa = 0;
    tick(3);
    check("early_sd_owner", ifa.bram_owner_out, 1);
    check("early_sd_busy", busy_a, 1);
    man_ca = 1; tick(); man_ca = 0;
    check("ign_sstart", ifa.stream_start_out, 1);
    check("ign_owner2", ifa.bram_owner_out, 2);
    tick(2);
    man_sa = 1; tick(); man_sa = 0;
    check("ign_done_lat", done_a, 1);
    check("ign_count", cnt_a, 2);
    tick();
    check("ign_idle", busy_a, 0);

    // Free-run paced to vsync; run wins over step_in in the same cycle
    auto_a = 1;
    cs0 = n_cs_a;
    run_a = 1; step_a = 1; tick(); step_a = 0;
    check("run_prio_nostart", ifa.collide_start_out, 0);
    check("run_prio_busy", busy_a, 1);
    tick(10);
    check("wsync_nostart", n_cs_a - cs0, 0);
    vsync_a = 1; tick(); vsync_a = 0;
    check("vs_cstart", ifa.collide_start_out, 1);
    wait_done_a("b1s1_tmo", 100);
    tick();
    check("b2b_cstart", ifa.collide_start_out, 1);
    wait_done_a("b1s2_tmo", 100);
    wait_done_a("b1s3_tmo", 100);
    tick(20);
    check("batch1_steps", n_cs_a - cs0, 3);
    check("batch1_count", cnt_a, 5);
    check("wsync_busy", busy_a, 1);
    check("wsync_owner", ifa.bram_owner_out, 0);
    vsync_a = 1; tick(); vsync_a = 0;
    tick(5);
    vsync_a = 1; tick(); vsync_a = 0;
    wait_done_a("b2s1_tmo", 100);
    wait_done_a("b2s2_tmo", 100);
    wait_done_a("b2s3_tmo", 100);
    tick(40);
    check("batch2_steps", n_cs_a - cs0, 6);
    check("batch2_count", cnt_a, 8);
    run_a = 0; tick(2);
    check("run_off_idle", busy_a, 0);

    // 17 single steps wrap the 4-bit counter; step_in while busy is dropped
    sd0 = n_sd_a;
    for (int i = 0; i < 17; i++) begin
      single_step_a();
      if (i == 0) begin
        tick(3);
        single_step_a();
      end
      wait_done_a("wrap_tmo", 100);
      tick();
    end
    tick();
    check("wrap_count", cnt_a, 9);
    check("wrap_pulses", n_sd_a - sd0, 17);
    check("wrap_idle", busy_a, 0);

    // Unpaced free-run; run drops mid third step, which still completes
    run_b = 1; tick(22); run_b = 0;
    for (int n = 0; n < 40 && busy_b; n++) tick();
    check("b_idle", busy_b, 0);
    check("b_count", cnt_b, 3);
    check("b_cpulses", n_cs_b, 3);
    check("b_dpulses", n_sd_b, 3);
    check("b_err", err_b, 0);

    // Watchdog: collide engine never answers
    auto_a = 0;
    cs0 = n_cs_a;
    single_step_a();
    tick(55);
    check("wd_early", err_a, 0);
    tick(15);
`ifdef LBM_WATCHDOG_EN
    check("wd_err", err_a, 1);
    check("wd_owner", ifa.bram_owner_out, 0);
    check("wd_busy", busy_a, 1);
    tick(10);
    check("wd_nostart", n_cs_a - cs0, 1);
`else
    check("wd_err_off", err_a, 0);
    check("wd_owner_off", ifa.bram_owner_out, 1);
`endif
    rst_in = 0; tick(); rst_in = 1; tick();
    check("rst_err_clr", err_a, 0);

    // Asynchronous reset while stream engine owns the banks
    single_step_a();
    tick();
    man_ca = 1; tick(); man_ca = 0;
    tick();
    check("pre_rst_owner", ifa.bram_owner_out, 2);
    cs0 = n_cs_a; ss0 = n_ss_a;
    #2 rst_in = 0;
    #1;
    check("arst_owner", ifa.bram_owner_out, 0);
    check("arst_busy", busy_a, 0);
    check("arst_count", cnt_a, 0);
    tick(3);
    check("arst_nocs", n_cs_a - cs0, 0);
    check("arst_noss", n_ss_a - ss0, 0);
    rst_in = 1; tick(2);
    check("post_rst_idle", busy_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
